// File: rtl/t_ff_pkg.sv
// Shared definitions for the T flip-flop bank: operating modes.
package t_ff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_t;

endpackage : t_ff_pkg

// File: rtl/t_ff_bank_if.sv
// Control/data bundle for t_ff_bank.
// Optional macro TFF_BANK_DOWN_EN adds the dn (count-down) signal.
interface t_ff_bank_if #(
  parameter int WIDTH = 8
);
  import t_ff_pkg::*;

  logic             en;
  mode_t            mode;
`ifdef TFF_BANK_DOWN_EN
  logic             dn;
`endif
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;

`ifdef TFF_BANK_DOWN_EN
  modport master (output en, mode, dn, t, d, input q, tc);
  modport slave  (input en, mode, dn, t, d, output q, tc);
`else
  modport master (output en, mode, t, d, input q, tc);
  modport slave  (input en, mode, t, d, output q, tc);
`endif

endinterface : t_ff_bank_if

// File: rtl/t_ff_cell.sv
// Single T flip-flop cell with synchronous parallel load.
// Load has priority over toggle; asynchronous active-low reset to RST_BIT.
module t_ff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  // State bit: reset, load, toggle or hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RST_BIT;
    else if (ld) q <= d;
    else if (t)  q <= ~q;
  end

endmodule : t_ff_cell

// File: rtl/t_ff_bank.sv
// WIDTH-bit bank of T flip-flops: hold, per-bit toggle, synchronous count
// built from T-cell toggle conditions, and parallel load. tc is a registered
// one-cycle pulse on the counting edge that wraps the bank.
// Optional macro TFF_BANK_DOWN_EN enables count-down through bus.dn.
module t_ff_bank
  import t_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  t_ff_bank_if.slave    bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chain;     // count toggle condition per cell
  logic [WIDTH-1:0] cell_t;
  logic             cell_ld;
  logic             wrap;      // all cells toggle: the count wraps this edge
  logic             tc_nxt;
  logic             tc_r;
  logic             count_dn;

`ifdef TFF_BANK_DOWN_EN
  assign count_dn = bus.dn;
`else
  assign count_dn = 1'b0;
`endif

  // Toggle chain: cell i toggles when all lower bits are 1 (up) or 0 (down).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic acc;
    chain = '0;
    acc   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      chain[i] = acc;
      acc      = acc & (q_r[i] ^ count_dn);
    end
    wrap = acc;
  end

  // Mode decode into per-cell toggle/load controls and the next tc value.
  always_comb begin
    cell_t  = '0;
    cell_ld = 1'b0;
    tc_nxt  = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_TOGGLE: cell_t = bus.t;
        MODE_COUNT: begin
          cell_t = chain;
          tc_nxt = wrap;
        end
        MODE_LOAD:   cell_ld = 1'b1;
        default:     ;
      endcase
    end
  end

  // One T flip-flop per bit, each with its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .t   (cell_t[i]),
      .ld  (cell_ld),
      .d   (bus.d[i]),
      .q   (q_r[i])
    );
  end

  // Terminal-count pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tc_r <= 1'b0;
    else      tc_r <= tc_nxt;
  end

  assign bus.q  = q_r;
  assign bus.tc = tc_r;

endmodule : t_ff_bank

// File: tb/tb_t_ff_bank.sv
// Self-checking bench for t_ff_bank (WIDTH=4): directed plan plus
// randomized traffic compared every cycle against an arithmetic model.
module tb_t_ff_bank;
  import t_ff_pkg::*;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk;
  logic rst;
  logic dn_m;       // direction seen by the model (always 0 without the option)
  bit   chk_en;
  int   checks;
  int   failures;

  t_ff_bank_if #(.WIDTH(W)) bus ();

  t_ff_bank #(
    .WIDTH   (W),
    .RST_VAL (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on an integer.
  int m_q;
  bit m_tc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q  <= 0;
      m_tc <= 1'b0;
    end else if (!bus.en) begin
      m_tc <= 1'b0;
    end else begin
      m_tc <= 1'b0;
      case (bus.mode)
        MODE_TOGGLE: m_q <= m_q ^ int'(bus.t);
        MODE_LOAD:   m_q <= int'(bus.d);
        MODE_COUNT: begin
          if (dn_m) begin
            m_q  <= (m_q + MAX) % (MAX + 1);
            m_tc <= (m_q == 0);
          end else begin
            m_q  <= (m_q + 1) % (MAX + 1);
            m_tc <= (m_q == MAX);
          end
        end
        default: ;
      endcase
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("q_vs_model", 32'(bus.q), 32'(m_q));
      check("tc_vs_model", 32'(bus.tc), 32'(m_tc));
    end
  end

  // Apply inputs, then advance one rising edge (+1 time unit).
  task automatic cyc(input logic e, input mode_t m, input logic [W-1:0] tv,
                     input logic [W-1:0] dv, input logic dnv);
    bus.en   = e;
    bus.mode = m;
    bus.t    = tv;
    bus.d    = dv;
`ifdef TFF_BANK_DOWN_EN
    bus.dn   = dnv;
    dn_m     = dnv;
`else
    dn_m     = 1'b0 & dnv;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic expect_qt(input string name, input logic [W-1:0] eq, input logic etc);
    check({name, "_q"}, 32'(bus.q), 32'(eq));
    check({name, "_tc"}, 32'(bus.tc), 32'(etc));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    dn_m     = 1'b0;
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.mode = MODE_COUNT;
    bus.t    = '0;
    bus.d    = '0;
`ifdef TFF_BANK_DOWN_EN
    bus.dn   = 1'b0;
`endif

    // Reset pulse between edges takes effect immediately.
    #2 rst = 1'b0;
    #1 expect_qt("reset_async", 4'b0000, 1'b0);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    expect_qt("first_edge_count", 4'b0001, 1'b0);

    // Toggle: 0000 -> 0101 -> 0000.
    cyc(1, MODE_LOAD, 4'b0000, 4'b0000, 0);
    cyc(1, MODE_TOGGLE, 4'b0101, 4'b1111, 0);
    expect_qt("toggle1", 4'b0101, 1'b0);
    cyc(1, MODE_TOGGLE, 4'b0101, 4'b1111, 0);
    expect_qt("toggle2", 4'b0000, 1'b0);

    // Wrap: load 1110 then three counts.
    cyc(1, MODE_LOAD, 4'b0000, 4'b1110, 0);
    expect_qt("load_1110", 4'b1110, 1'b0);
    cyc(1, MODE_COUNT, 4'b1111, 4'b0000, 0);
    expect_qt("wrap_pre", 4'b1111, 1'b0);
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    expect_qt("wrap", 4'b0000, 1'b1);
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    expect_qt("wrap_post", 4'b0001, 1'b0);

    // Enable gating.
    cyc(1, MODE_LOAD, 4'b0000, 4'b0011, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, MODE_COUNT, 4'b1111, 4'b1111, 0);
      expect_qt("en_low_hold", 4'b0011, 1'b0);
    end
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    expect_qt("en_high_count", 4'b0100, 1'b0);

    // Hold mode keeps state.
    cyc(1, MODE_HOLD, 4'b1111, 4'b1111, 0);
    expect_qt("hold", 4'b0100, 1'b0);

    // Reset mid-count.
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    expect_qt("count_to_6", 4'b0110, 1'b0);
    #2 rst = 1'b0;
    #1 expect_qt("reset_mid", 4'b0000, 1'b0);
    #1 rst = 1'b1;
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 0);
    expect_qt("resume", 4'b0001, 1'b0);

`ifdef TFF_BANK_DOWN_EN
    // Down-count through zero.
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 1);
    expect_qt("down_to_0", 4'b0000, 1'b0);
    cyc(1, MODE_COUNT, 4'b0000, 4'b0000, 1);
    expect_qt("down_wrap", 4'b1111, 1'b1);
`endif

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      int    r;
      mode_t m;
      r = int'($urandom_range(0, 9));
      if (r < 5)      m = MODE_COUNT;
      else if (r < 7) m = MODE_TOGGLE;
      else if (r < 8) m = MODE_LOAD;
      else            m = MODE_HOLD;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      cyc(($urandom_range(0, 7) != 0), m, W'($urandom), W'($urandom),
          1'($urandom));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_t_ff_bank
